// File: rtl/fifo_wptr_full.sv
// Write-side pointer/full stage: binary write pointer, registered Gray export, 2-flop rd-ptr sync, full/overflow flags.
// Latency: waddr/wptr_gray/full update on the accepting edge; a read-pointer advance reaches full after 3 edges.
// Backpressure: wr_accept = wr_en & ~full; writes while full are dropped and latch the sticky overflow flag.
//
// Ports: clk/rst (async active-high), wr_en, rptr_gray_async (unsynchronised Gray read pointer) in;
//        waddr, wr_accept, wptr_gray, full, overflow out; almost_full only with FIFO_ALMOST_FULL_EN.
// Optional feature macro: FIFO_ALMOST_FULL_EN (adds Gray-to-binary of the synced read pointer and almost_full).
module fifo_wptr_full #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   rptr_gray_async,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic                 wr_accept,
  output logic [ADDR_SIZE:0]   wptr_gray,
  output logic                 full,
  output logic                 overflow
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                 almost_full
`endif
);

  // The full compare slices rq2 below bit ADDR_SIZE-1, so at least 2 address bits are needed.
  if (ADDR_SIZE < 2 || AF_MARGIN < 0 || AF_MARGIN > (1 << ADDR_SIZE)) begin : g_bad_params
    $error("fifo_wptr_full: ADDR_SIZE must be >= 2 and AF_MARGIN within 0..2**ADDR_SIZE");
  end

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wgray_q, wgray_d;
  logic [ADDR_SIZE:0] rq1_q, rq1_d;
  logic [ADDR_SIZE:0] rq2_q, rq2_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_SIZE:0] AF_THRESH = (ADDR_SIZE+1)'((1 << ADDR_SIZE) - AF_MARGIN);
  logic [ADDR_SIZE:0] rbin_s;
  logic [ADDR_SIZE:0] count_s;
  logic               af_q, af_d;
`endif

  assign wr_accept = wr_en & ~full_q;
  assign waddr     = wbin_q[ADDR_SIZE-1:0];
  assign wptr_gray = wgray_q;
  assign full      = full_q;
  assign overflow  = overflow_q;

  always_comb begin
    wbin_d     = wbin_q + {{ADDR_SIZE{1'b0}}, wr_accept};
    wgray_d    = wbin_d ^ (wbin_d >> 1);
    rq1_d      = rptr_gray_async;
    rq2_d      = rq1_q;
    // Full when the write pointer is one lap ahead of the synced read pointer:
    // in Gray code that is the top two bits inverted, the rest equal.
    full_d     = (wgray_d == {~rq2_q[ADDR_SIZE:ADDR_SIZE-1], rq2_q[ADDR_SIZE-2:0]});
    overflow_d = overflow_q | (wr_en & full_q);
  end

`ifdef FIFO_ALMOST_FULL_EN
  always_comb begin
    rbin_s            = '0;
    rbin_s[ADDR_SIZE] = rq2_q[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ rq2_q[i];
    end
    count_s = wbin_d - rbin_s;
    af_d    = (count_s >= AF_THRESH);
  end

  assign almost_full = af_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= af_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      rq1_q      <= '0;
      rq2_q      <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      rq1_q      <= rq1_d;
      rq2_q      <= rq2_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;
  localparam int A     = 4;
  localparam int DEPTH = 1 << A;
  localparam int PMOD  = 2 * DEPTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [A:0]   rptr_gray_async;
  logic [A-1:0] waddr;
  logic         wr_accept;
  logic [A:0]   wptr_gray;
  logic         full;
  logic         overflow;
`ifdef FIFO_ALMOST_FULL_EN
  logic         almost_full;
`endif

  fifo_wptr_full #(.ADDR_SIZE(A), .AF_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rptr_gray_async(rptr_gray_async),
    .waddr(waddr), .wr_accept(wr_accept), .wptr_gray(wptr_gray),
    .full(full), .overflow(overflow)
`ifdef FIFO_ALMOST_FULL_EN
    , .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts of accepted writes and of reads the writer has seen.
  int wtot;         // total accepted writes since reset
  int rb;           // read pointer presented on the input (binary, unbounded)
  int seen1, seen2; // read-pointer values as seen 1 and 2 edges ago
  bit full_m, ovf_m, af_m;

  function automatic logic [A:0] gray(input int b);
    logic [A:0] v;
    v = A'(0);
    v = (A+1)'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_waddr"}, 32'(waddr), 32'(wtot % DEPTH));
    chk({tag, "_gray"}, 32'(wptr_gray), 32'(gray(wtot)));
    chk({tag, "_full"}, 32'(full), 32'(full_m));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ovf_m));
`ifdef FIFO_ALMOST_FULL_EN
    chk({tag, "_af"}, 32'(almost_full), 32'(af_m));
`endif
  endtask

  // One write-clock cycle: present inputs, check the combinational accept, clock, check state.
  task automatic step(input string tag, input bit we, input int rptr);
    bit acc;
    int occ;
    logic [A:0] prev_gray;
    wr_en = we;
    rb = rptr;
    rptr_gray_async = gray(rptr);
    #1;
    acc = we && !full_m;
    chk({tag, "_acc"}, 32'(wr_accept), 32'(acc));
    prev_gray = wptr_gray;
    @(posedge clk);
    ovf_m = ovf_m | (we && full_m);
    if (acc) wtot++;
    occ = ((wtot - seen2) % PMOD + PMOD) % PMOD;
    full_m = (occ == DEPTH);
    af_m = (occ >= DEPTH - 2);
    seen2 = seen1;
    seen1 = rptr;
    #1;
    chk({tag, "_1bit"}, 32'($countones(wptr_gray ^ prev_gray)), 32'(acc));
    chk_outputs(tag);
  endtask

  task automatic model_reset();
    wtot = 0; rb = 0; seen1 = 0; seen2 = 0;
    full_m = 0; ovf_m = 0; af_m = 0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rptr_gray_async = '0;
    model_reset();
    #3;
    chk_outputs("reset");
    chk("reset_acc", 32'(wr_accept), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill with the read pointer held at 0.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_gray", 32'(wptr_gray), 32'b11000);
    chk("fill_ovf", 32'(overflow), 32'd0);

    // Writes while full are blocked and set overflow.
    for (int i = 0; i < 3; i++) begin
      step("blocked", 1'b1, 0);
      chk("blocked_ovf", 32'(overflow), 32'd1);
    end

    // Read pointer advances by one: full clears on the third edge, not earlier.
    step("rd1_e1", 1'b0, 1);
    chk("rd1_full_e1", 32'(full), 32'd1);
    step("rd1_e2", 1'b0, 1);
    chk("rd1_full_e2", 32'(full), 32'd1);
    step("rd1_e3", 1'b0, 1);
    chk("rd1_full_e3", 32'(full), 32'd0);
    chk("rd1_waddr", 32'(waddr), 32'd0);
    step("rd1_wr", 1'b1, 1);

    // Reader catches up, then tracks the writer across the pointer wrap.
    while (rb < wtot) step("catchup", 1'b0, rb + 1);
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'b1, wtot);
      chk("wrap_nofull", 32'(full), 32'd0);
    end

    // Random producer/consumer traffic; the reader never passes the writer.
    for (int i = 0; i < 400; i++) begin
      int nr;
      nr = rb;
      if (nr < wtot && $urandom_range(0, 2) != 0) nr++;
      step("rand", ($urandom_range(0, 3) != 0), nr);
    end

    // Reset asserted between edges mid-burst clears everything at once.
    step("burst", 1'b1, rb);
    step("burst", 1'b1, rb);
    #2;
    rst = 1'b1;
    wr_en = 1'b1;
    rptr_gray_async = '0;
    #1;
    model_reset();
    chk_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_waddr", 32'(waddr), 32'd0);
    step("post_rst", 1'b1, 0);

`ifdef FIFO_ALMOST_FULL_EN
    rst = 1'b1;
    wr_en = 1'b0;
    rptr_gray_async = '0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      step("af_fill", 1'b1, 0);
      chk("af_flag", 32'(almost_full), 32'(i >= DEPTH - 2));
      chk("af_full", 32'(full), 32'(i == DEPTH));
    end
    for (int i = 0; i < 3; i++) step("af_rd3", 1'b0, 3);
    chk("af_clear", 32'(almost_full), 32'd0);
    chk("af_full_clear", 32'(full), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
